// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU datapath.
//   DATA_W            : datapath width
//   FLAG_C/Z/V        : bit positions of carry, zero and overflow in a flag vector
//   alu_op_e          : ALU operation, encoded as {use_carry, sub}
package cpu_pkg;

  localparam int DATA_W = 8;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } alu_op_e;

endpackage

// File: rtl/adder8.sv
// 8-bit ripple adder with carry-in and carry-out.
//   a, b  : operands
//   cin   : carry in
//   sum   : a + b + cin, low 8 bits
//   cout  : carry out of bit 7
module adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};

endmodule

// File: rtl/alu_stage.sv
// Arithmetic stage of the 8-bit CPU datapath.
// Holds operand registers A/B loaded from the shared bus, registers the
// adder result, tracks whether that result matches the current operands
// and controls, latches C/Z/V on command and drives the result onto the bus.
//   clk, rst          : clock, asynchronous active-high reset
//   bus_in            : shared bus value
//   load_a, load_b    : capture bus_in into A / B
//   sub, use_carry    : operation select ({use_carry, sub} = ADD/SUB/ADC/SBC)
//   flags_we          : latch flags from the registered result
//   out_en            : drive the result onto the bus
//   bus_out, bus_oe   : bus drive (0 when not enabled)
//   a_q, b_q          : operand registers
//   res_valid         : registered result reflects current operands/controls
//   flag_c/z/v        : carry (not-borrow), zero, signed overflow
module alu_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             sub,
  input  logic             use_carry,
  input  logic             flags_we,
  input  logic             out_en,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic             res_valid,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_v
);

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             cin;
  alu_op_e          op;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             v_q;
  logic             sub_q;
  logic             uc_q;
  logic [2:0]       flags_q;

  always_comb begin
    op  = alu_op_e'({use_carry, sub});
    bin = b_q ^ {WIDTH{sub}};
    cin = sub;
    case (op)
      OP_ADD:         cin = 1'b0;
      OP_SUB:         cin = 1'b1;
      OP_ADC, OP_SBC: cin = flags_q[FLAG_C];
      default:        cin = sub;
    endcase
  end

  adder8 u_adder (
    .a    (a_q),
    .b    (bin),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      v_q       <= 1'b0;
      sub_q     <= 1'b0;
      uc_q      <= 1'b0;
      res_valid <= 1'b0;
      flags_q   <= '0;
    end else begin
      if (load_a) a_q <= bus_in;
      if (load_b) b_q <= bus_in;
      sum_q  <= sum;
      cout_q <= cout;
      v_q    <= (a_q[WIDTH-1] == bin[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      sub_q  <= sub;
      uc_q   <= use_carry;
      // Writing flags during ADC/SBC changes cin, so the sum computed this
      // cycle is stale even though operands did not move.
      res_valid <= !(load_a | load_b | (flags_we & use_carry)) &&
                   (sub == sub_q) && (use_carry == uc_q);
      if (flags_we && res_valid) begin
        flags_q[FLAG_C] <= cout_q;
        flags_q[FLAG_Z] <= (sum_q == '0);
        flags_q[FLAG_V] <= v_q;
      end
    end
  end

  assign flag_c  = flags_q[FLAG_C];
  assign flag_z  = flags_q[FLAG_Z];
  assign flag_v  = flags_q[FLAG_V];

  assign bus_out = out_en ? sum_q : '0;
  assign bus_oe  = out_en;

endmodule

// File: tb/tb_alu_stage.sv
module tb_alu_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus_in;
  logic       load_a, load_b, sub, use_carry, flags_we, out_en;
  logic [7:0] bus_out, a_q, b_q;
  logic       bus_oe, res_valid, flag_c, flag_z, flag_v;

  alu_stage #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in),
    .load_a(load_a), .load_b(load_b), .sub(sub), .use_carry(use_carry),
    .flags_we(flags_we), .out_en(out_en),
    .bus_out(bus_out), .bus_oe(bus_oe), .a_q(a_q), .b_q(b_q),
    .res_valid(res_valid), .flag_c(flag_c), .flag_z(flag_z), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state (plain integers)
  int m_a, m_b, m_sum, m_c, m_v, m_valid, m_psub, m_puc, m_fc, m_fz, m_fv;

  typedef struct {
    int a; int b; int sub; int uc;
    int sum; int c; int z; int v;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_sum = 0; m_c = 0; m_v = 0; m_valid = 0;
    m_psub = 0; m_puc = 0; m_fc = 0; m_fz = 0; m_fv = 0;
  endtask

  function automatic int to_signed8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  task automatic check_model();
    chk("a_q", int'(a_q), m_a);
    chk("b_q", int'(b_q), m_b);
    chk("res_valid", int'(res_valid), m_valid);
    chk("flag_c", int'(flag_c), m_fc);
    chk("flag_z", int'(flag_z), m_fz);
    chk("flag_v", int'(flag_v), m_fv);
    chk("bus_out", int'(bus_out), out_en ? m_sum : 0);
    chk("bus_oe", int'(bus_oe), int'(out_en));
  endtask

  // One clock edge: predict from pre-edge inputs, then compare after the edge.
  task automatic tick();
    int bv, ci, full, ss;
    int n_a, n_b, n_sum, n_c, n_v, n_valid, n_fc, n_fz, n_fv;
    bv   = sub ? 255 - m_b : m_b;
    ci   = use_carry ? m_fc : int'(sub);
    full = m_a + bv + ci;
    ss   = to_signed8(m_a) + to_signed8(bv) + ci;
    n_sum = full % 256;
    n_c   = (full > 255) ? 1 : 0;
    n_v   = (ss > 127 || ss < -128) ? 1 : 0;
    n_a   = load_a ? int'(bus_in) : m_a;
    n_b   = load_b ? int'(bus_in) : m_b;
    n_valid = (!(load_a || load_b || (flags_we && use_carry)) &&
               int'(sub) == m_psub && int'(use_carry) == m_puc) ? 1 : 0;
    n_fc = m_fc; n_fz = m_fz; n_fv = m_fv;
    if (flags_we && m_valid == 1) begin
      n_fc = m_c; n_fz = (m_sum == 0) ? 1 : 0; n_fv = m_v;
    end
    @(posedge clk);
    m_a = n_a; m_b = n_b; m_sum = n_sum; m_c = n_c; m_v = n_v;
    m_valid = n_valid; m_psub = int'(sub); m_puc = int'(use_carry);
    m_fc = n_fc; m_fz = n_fz; m_fv = n_fv;
    #1;
    check_model();
  endtask

  task automatic run_vec(input vec_t v);
    sub = v.sub[0]; use_carry = v.uc[0];
    bus_in = v.a[7:0]; load_a = 1'b1; tick();
    load_a = 1'b0; bus_in = v.b[7:0]; load_b = 1'b1; tick();
    load_b = 1'b0; tick();
    chk("vec_valid", int'(res_valid), 1);
    flags_we = 1'b1; out_en = 1'b1; tick();
    flags_we = 1'b0;
    chk("vec_sum", int'(bus_out), v.sum);
    chk("vec_c", int'(flag_c), v.c);
    chk("vec_z", int'(flag_z), v.z);
    chk("vec_v", int'(flag_v), v.v);
    out_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{'h3C, 'h05, 0, 0, 'h41, 0, 0, 0};
    vecs[1] = '{'h20, 'h20, 1, 0, 'h00, 1, 1, 0};
    vecs[2] = '{'h10, 'h20, 1, 0, 'hF0, 0, 0, 0};
    vecs[3] = '{'hFF, 'h01, 0, 0, 'h00, 1, 1, 0};
    vecs[4] = '{'h7F, 'h01, 0, 0, 'h80, 0, 0, 1};
    vecs[5] = '{'hF0, 'h20, 0, 0, 'h10, 1, 0, 0};  // low byte of 16-bit add
    vecs[6] = '{'h01, 'h02, 0, 1, 'h04, 0, 0, 0};  // ADC high byte, C=1 in
    vecs[7] = '{'h05, 'h03, 1, 1, 'h01, 1, 0, 0};  // SBC with borrow in

    rst = 1'b1; bus_in = '0; load_a = 0; load_b = 0; sub = 0;
    use_carry = 0; flags_we = 0; out_en = 1'b1;
    model_reset();
    #12;
    chk("rst_a_q", int'(a_q), 0);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_bus_out", int'(bus_out), 0);
    chk("rst_flags", int'({flag_v, flag_z, flag_c}), 0);
    #1 rst = 1'b0; out_en = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // flags_we while result invalid is ignored (flags from SBC: C=1 Z=0 V=0)
    sub = 0; use_carry = 0; bus_in = 8'h00; load_a = 1'b1; tick();
    load_a = 1'b0; flags_we = 1'b1; tick();
    chk("ign_c", int'(flag_c), 1);
    chk("ign_z", int'(flag_z), 0);
    chk("ign_valid_after", int'(res_valid), 1);
    // load_a with flags_we: flags from old sum 0x00+0x03
    bus_in = 8'hFF; load_a = 1'b1; tick();
    load_a = 1'b0; flags_we = 1'b0;
    chk("simul_c", int'(flag_c), 0);
    chk("simul_z", int'(flag_z), 0);
    chk("simul_valid", int'(res_valid), 0);

    // control churn
    tick();
    chk("churn_pre", int'(res_valid), 1);
    sub = 1'b1; tick();
    chk("churn_low", int'(res_valid), 0);
    tick();
    chk("churn_back", int'(res_valid), 1);
    bus_in = 8'h12; load_a = 1'b1; load_b = 1'b1; tick();
    load_a = 1'b0; load_b = 1'b0;
    chk("both_a", int'(a_q), 'h12);
    chk("both_b", int'(b_q), 'h12);
    chk("both_low", int'(res_valid), 0);
    tick();
    chk("both_back", int'(res_valid), 1);

    // asynchronous reset mid-cycle
    sub = 0; bus_in = 8'h55; load_a = 1'b1; tick();
    load_a = 1'b0; tick();
    chk("pre_rst_a", int'(a_q), 'h55);
    out_en = 1'b1;
    #3 rst = 1'b1;
    #1;
    chk("arst_a_q", int'(a_q), 0);
    chk("arst_sum", int'(bus_out), 0);
    chk("arst_valid", int'(res_valid), 0);
    chk("arst_flags", int'({flag_v, flag_z, flag_c}), 0);
    model_reset();
    #2 rst = 1'b0; out_en = 1'b0;

    // randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      bus_in   = 8'($urandom);
      load_a   = ($urandom % 4) == 0;
      load_b   = ($urandom % 4) == 0;
      flags_we = ($urandom % 3) == 0;
      out_en   = ($urandom % 2) == 0;
      if (($urandom % 8) == 0) sub = ~sub;
      if (($urandom % 8) == 0) use_carry = ~use_carry;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_stage.md
Name: alu_stage

Overview:
- Arithmetic stage of the 8-bit CPU datapath. Holds the A and B operand registers loaded from the shared bus and drives the existing adder8 for ADD/SUB/ADC/SBC.
- Registers the sum and tracks result validity. Latches carry, zero and overflow flags on command.
- Drives the sum back onto the bus under control-unit enable.

Parameters:
- WIDTH, 8, datapath width; only 8 is supported because adder8 is fixed-width.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- bus_in  input  WIDTH  shared data bus value
- load_a  input  1  capture bus_in into A at the next edge
- load_b  input  1  capture bus_in into B at the next edge
- sub  input  1  0 = add, 1 = subtract (B inverted)
- use_carry  input  1  1 = carry-in taken from flag_c (ADC/SBC)
- flags_we  input  1  latch flags from the current result
- out_en  input  1  drive the result onto the bus
- bus_out  output  WIDTH  sum_q when out_en, else 0
- bus_oe  output  1  equals out_en
- a_q  output  WIDTH  A register
- b_q  output  WIDTH  B register
- res_valid  output  1  sum_q reflects current operands and controls
- flag_c  output  1  carry / not-borrow
- flag_z  output  1  zero
- flag_v  output  1  signed overflow

Behaviour:
- Clocking and reset: single clock, clk. Reset rst is asynchronous and active-high.
- Reset values: a_q, b_q, sum_q, cout_q, v_q = 0; flag_c, flag_z, flag_v = 0; res_valid = 0; sub_q, uc_q = 0. Reset takes effect mid-operation immediately, without waiting for a clock edge.
- Operand load: load_a / load_b capture bus_in at the rising edge. Both may assert in the same cycle; both capture.
- Adder inputs:
  - bin = b_q XOR {WIDTH{sub}}.
  - cin = use_carry ? flag_c : sub.
  - Carry follows the not-borrow convention: SUB of equal values gives C = 1.
- Compute register: every edge, sum_q <= adder8 sum, cout_q <= adder8 carry_out, v_q <= (a_q[7] == bin[7]) && (sum[7] != a_q[7]).
- sub_q / uc_q: register sub / use_carry every edge.
- res_valid (registered):
  - res_valid <= !(load_a | load_b | (flags_we & use_carry)) && (sub == sub_q) && (use_carry == uc_q).
  - Latency: the load edge clears res_valid. The next edge with stable inputs sets it. The result is valid 2 edges after a load.
  - Any change of sub or use_carry clears res_valid for one cycle.
- Flag latch: on an edge with flags_we && res_valid: flag_c <= cout_q, flag_z <= (sum_q == 0), flag_v <= v_q.
  - flags_we while !res_valid is ignored; flags hold.
- Bus output: bus_out / bus_oe are combinational from out_en and sum_q, with no clock latency. out_en while !res_valid still drives the stale sum_q; the control unit guarantees sequencing.
- Wrap-around: 0xFF + 0x01 gives sum 0x00 with C = 1 and Z = 1. 0x7F + 0x01 gives 0x80 with V = 1.
- Simultaneous events: load_a with flags_we latches flags from the old sum_q, because res_valid was 1 before that edge. The next result is then invalid.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W = 8.
  - Flag bit indices FLAG_C = 0, FLAG_Z = 1, FLAG_V = 2.
  - ALU op encoding {use_carry, sub}: ADD = 2'b00, SUB = 2'b01, ADC = 2'b10, SBC = 2'b11.
- Sub-module: reuse the existing adder8 as the single instance for the combinational sum. The remaining logic is registers and validity tracking in this block.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with A = 0x55 loaded -> a_q, sum_q, flags, res_valid all 0 immediately.
- ADD with flags: load A = 0x3C, B = 0x05, sub = 0, wait 2 edges -> res_valid = 1, sum 0x41. Then flags_we -> C = 0, Z = 0, V = 0. out_en -> bus_out = 0x41, bus_oe = 1.
- SUB of equal values: A = 0x20, B = 0x20, sub = 1 -> sum 0x00, C = 1, Z = 1 after flags_we. Then A = 0x10, B = 0x20 -> 0xF0, C = 0.
- Wrap and overflow: A = 0xFF, B = 0x01 -> 0x00, C = 1, Z = 1. Then A = 0x7F, B = 0x01 -> 0x80, V = 1, C = 0.
- 16-bit add via ADC: low bytes 0xF0 + 0x20 (ADD, flags_we) -> 0x10, C = 1. Then high bytes 0x01 + 0x02 with use_carry = 1 -> 0x04. Also check flags_we while res_valid = 0 leaves flags unchanged.
- Control churn: toggle sub on an edge -> res_valid = 0 for one cycle then 1. Simultaneous load_a + load_b -> both captured, res_valid low exactly one cycle.
